// File: rtl/div_pkg.sv
// Shared types and widths for the streaming 4-bit divider unit.
package div_pkg;

   localparam int DIV_W = 4;
   localparam int TAG_W = 4;

   typedef struct packed {
      logic [DIV_W-1:0] a;
      logic [DIV_W-1:0] b;
      logic [TAG_W-1:0] tag;
   } div_req_t;

   typedef struct packed {
      logic [DIV_W-1:0] q;
      logic [DIV_W-1:0] r;
      logic [TAG_W-1:0] tag;
      logic             err;
   } div_rsp_t;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } out_state_t;

endpackage

// File: rtl/div_array.sv
// Combinational unsigned restoring array divider; b == 0 yields q = all ones, r = a.
module div_array
   import div_pkg::*;
(
   input  logic [DIV_W-1:0] a,
   input  logic [DIV_W-1:0] b,
   output logic [DIV_W-1:0] q,
   output logic [DIV_W-1:0] r
);

   logic [DIV_W:0] rem;

   always_comb begin
      // NOTE: blocking assignments here are intentional; each loop stage feeds the next row.
      rem = '0;
      q   = '0;
      for (int i = DIV_W - 1; i >= 0; i--) begin
         rem = {rem[DIV_W-1:0], a[i]};
         if (rem >= {1'b0, b}) begin
            rem  = rem - {1'b0, b};
            q[i] = 1'b1;
         end
      end
      r = rem[DIV_W-1:0];
   end

endmodule

// File: rtl/div_req_fifo.sv
// Small circular operand queue holding {a, b, tag}; head is read combinationally.
module div_req_fifo
   import div_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  div_req_t                     push_data,
   input  logic                         pop,
   output div_req_t                     head,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   div_req_t        mem [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;

   // NOTE: storage is deliberately not reset; pointers and count make stale entries unreachable.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
         if (pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/div_stream_unit.sv
// Valid/ready streaming wrapper: operand queue -> array divider -> registered result.
// Optional macro DIV_ZERO_CHECK_EN replaces divide-by-zero results with q=0, r=0, err=1.
module div_stream_unit
   import div_pkg::*;
#(
   parameter int QDEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [DIV_W-1:0] in_a,
   input  logic [DIV_W-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [DIV_W-1:0] out_q,
   output logic [DIV_W-1:0] out_r,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_err
);

   localparam int CW = $clog2(QDEPTH + 1);

   logic [CW-1:0]    count;
   logic             push;
   logic             load;
   logic [TAG_W-1:0] tag_cnt;
   div_req_t         push_data;
   div_req_t         head;
   logic [DIV_W-1:0] div_q;
   logic [DIV_W-1:0] div_r;
   div_rsp_t         rsp_next;
   div_rsp_t         rsp;
   out_state_t       state;

   // in_ready looks only at the registered count, never at a same-cycle pop.
   assign in_ready  = (count < CW'(QDEPTH));
   assign push      = in_valid && in_ready;
   assign push_data = '{a: in_a, b: in_b, tag: tag_cnt};
   assign load      = (count != '0) && ((state == ST_EMPTY) || out_ready);

   div_req_fifo #(
      .DEPTH     (QDEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (push_data),
      .pop       (load),
      .head      (head),
      .count     (count)
   );

   div_array u_div (
      .a (head.a),
      .b (head.b),
      .q (div_q),
      .r (div_r)
   );

   always_comb begin
      // NOTE: full default first so no branch can leave rsp_next unassigned (no latch).
      rsp_next = '{q: div_q, r: div_r, tag: head.tag, err: 1'b0};
`ifdef DIV_ZERO_CHECK_EN
      if (head.b == '0) begin
         rsp_next.q   = '0;
         rsp_next.r   = '0;
         rsp_next.err = 1'b1;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tag_cnt <= '0;
      else if (push) tag_cnt <= tag_cnt + TAG_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_EMPTY;
         rsp   <= '0;
      end else if (load) begin
         state <= ST_FULL;
         rsp   <= rsp_next;
      end else if (state == ST_FULL && out_ready) begin
         state <= ST_EMPTY;
      end
   end

   assign out_valid = (state == ST_FULL);
   assign out_q     = rsp.q;
   assign out_r     = rsp.r;
   assign out_tag   = rsp.tag;
   assign out_err   = rsp.err;

endmodule

// File: tb/tb_div_stream_unit.sv
// Scoreboard bench for div_stream_unit: expectations queued on accept, compared on transfer.
module tb_div_stream_unit;
   import div_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b0;
   logic [3:0] in_a = '0;
   logic [3:0] in_b = '0;
   logic       in_ready;
   logic       out_valid;
   logic [3:0] out_q;
   logic [3:0] out_r;
   logic [3:0] out_tag;
   logic       out_err;

   int         checks = 0;
   int         failures = 0;
   div_rsp_t   sb[$];
   div_rsp_t   mon_exp;
   logic [3:0] exp_tag = '0;

   always #5 clk = ~clk;

   div_stream_unit #(.QDEPTH(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_q     (out_q),
      .out_r     (out_r),
      .out_tag   (out_tag),
      .out_err   (out_err)
   );

   function automatic div_rsp_t model(input logic [3:0] a, input logic [3:0] b,
                                      input logic [3:0] tag);
      div_rsp_t m;
      m.tag = tag;
      m.err = 1'b0;
      if (b == 4'd0) begin
`ifdef DIV_ZERO_CHECK_EN
         m.q   = 4'd0;
         m.r   = 4'd0;
         m.err = 1'b1;
`else
         m.q   = 4'hF;
         m.r   = a;
`endif
      end else begin
         m.q = a / b;
         m.r = a % b;
      end
      return m;
   endfunction

   // Mid-cycle monitor: record accepts, then compare any result being handed over.
   always @(negedge clk) begin
      if (rst_n) begin
         if (in_valid && in_ready) begin
            sb.push_back(model(in_a, in_b, exp_tag));
            exp_tag = exp_tag + 4'd1;
         end
         if (out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL sb_unexpected: got q=%0d r=%0d tag=%0d err=%0b, required no result",
                        out_q, out_r, out_tag, out_err);
            end else begin
               mon_exp = sb.pop_front();
               if ({out_q, out_r, out_tag, out_err} !== mon_exp) begin
                  failures++;
                  $display("FAIL sb_result: got q=%0d r=%0d tag=%0d err=%0b, required q=%0d r=%0d tag=%0d err=%0b",
                           out_q, out_r, out_tag, out_err,
                           mon_exp.q, mon_exp.r, mon_exp.tag, mon_exp.err);
               end
            end
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      rst_n     = 1'b0;
      sb.delete();
      exp_tag   = '0;
      next_cycle();
      next_cycle();
      rst_n = 1'b1;
   endtask

   task automatic check_drained(input string name);
      checks++;
      if (sb.size() != 0 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL %s_drained: got pending=%0d out_valid=%b, required pending=0 out_valid=0",
                  name, sb.size(), out_valid);
      end
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if ({in_ready, out_valid, out_q, out_r, out_tag, out_err} !== {1'b1, 1'b0, 12'h000, 1'b0}) begin
         failures++;
         $display("FAIL reset_during: got rdy=%b vld=%b q=%0d r=%0d tag=%0d err=%b, required 1 0 0 0 0 0",
                  in_ready, out_valid, out_q, out_r, out_tag, out_err);
      end
      apply_reset();
      checks++;
      if ({in_ready, out_valid, out_q, out_r, out_tag, out_err} !== {1'b1, 1'b0, 12'h000, 1'b0}) begin
         failures++;
         $display("FAIL reset_after: got rdy=%b vld=%b q=%0d r=%0d tag=%0d err=%b, required 1 0 0 0 0 0",
                  in_ready, out_valid, out_q, out_r, out_tag, out_err);
      end
   endtask

   task automatic test_single();
      out_ready = 1'b1;
      in_a = 4'd13; in_b = 4'd4; in_valid = 1'b1;
      next_cycle();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL single_early: got out_valid=%b, required 0", out_valid);
      end
      next_cycle();
      checks++;
      if ({out_valid, out_q, out_r, out_tag, out_err} !== {1'b1, 4'd3, 4'd1, 4'd0, 1'b0}) begin
         failures++;
         $display("FAIL single_result: got vld=%b q=%0d r=%0d tag=%0d err=%b, required 1 3 1 0 0",
                  out_valid, out_q, out_r, out_tag, out_err);
      end
      next_cycle();
      check_drained("single");
   endtask

   task automatic test_back_to_back();
      logic [3:0] pa [3];
      logic [3:0] pb [3];
      logic [3:0] eq [3];
      logic [3:0] er [3];
      logic [3:0] base;
      pa = '{4'd15, 4'd9, 4'd7};
      pb = '{4'd3,  4'd2, 4'd7};
      eq = '{4'd5,  4'd4, 4'd1};
      er = '{4'd0,  4'd1, 4'd0};
      base = exp_tag;
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (i < 3) begin
            in_a = pa[i]; in_b = pb[i]; in_valid = 1'b1;
            checks++;
            if (in_ready !== 1'b1) begin
               failures++;
               $display("FAIL b2b_ready[%0d]: got %b, required 1", i, in_ready);
            end
         end else begin
            in_valid = 1'b0;
         end
         if (i >= 2) begin
            checks++;
            if ({out_valid, out_q, out_r, out_tag} !== {1'b1, eq[i-2], er[i-2], base + 4'(i - 2)}) begin
               failures++;
               $display("FAIL b2b_out[%0d]: got vld=%b q=%0d r=%0d tag=%0d, required 1 %0d %0d %0d",
                        i - 2, out_valid, out_q, out_r, out_tag, eq[i-2], er[i-2], base + 4'(i - 2));
            end
         end
         next_cycle();
      end
      check_drained("b2b");
   endtask

   task automatic test_backpressure();
      logic [3:0] pa [4];
      logic [3:0] pb [4];
      logic [3:0] nt;
      logic       push_now;
      int         cyc;
      pa = '{4'd11, 4'd14, 4'd8, 4'd6};
      pb = '{4'd3,  4'd5,  4'd8, 4'd4};
      apply_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_a = pa[i]; in_b = pb[i]; in_valid = 1'b1;
         checks++;
         if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_accept[%0d]: got in_ready=%b, required 1", i, in_ready);
         end
         next_cycle();
      end
      in_a = pa[3]; in_b = pb[3];
      for (int h = 0; h < 3; h++) begin
         checks++;
         if ({in_ready, out_valid, out_tag} !== {1'b0, 1'b1, 4'd0}) begin
            failures++;
            $display("FAIL bp_stall[%0d]: got rdy=%b vld=%b tag=%0d, required 0 1 0",
                     h, in_ready, out_valid, out_tag);
         end
         if (h < 2) next_cycle();
      end
      out_ready = 1'b1;
      nt = '0;
      cyc = 0;
      while ((out_valid || in_valid) && cyc < 20) begin
         if (out_valid) begin
            checks++;
            if (out_tag !== nt) begin
               failures++;
               $display("FAIL bp_order: got tag=%0d, required %0d", out_tag, nt);
            end
            nt = nt + 4'd1;
         end
         push_now = in_valid && in_ready;
         next_cycle();
         if (push_now) in_valid = 1'b0;
         cyc++;
      end
      checks++;
      if (cyc >= 20 || nt !== 4'd4) begin
         failures++;
         $display("FAIL bp_drain: got results=%0d cycles=%0d, required results=4 within 20 cycles",
                  nt, cyc);
      end
      check_drained("bp");
   endtask

   task automatic test_div_zero();
      logic [3:0] tag;
      tag = exp_tag;
      out_ready = 1'b1;
      in_a = 4'd9; in_b = 4'd0; in_valid = 1'b1;
      next_cycle();
      in_valid = 1'b0;
      next_cycle();
      checks++;
`ifdef DIV_ZERO_CHECK_EN
      if ({out_valid, out_q, out_r, out_tag, out_err} !== {1'b1, 4'd0, 4'd0, tag, 1'b1}) begin
         failures++;
         $display("FAIL div_zero: got vld=%b q=%0d r=%0d tag=%0d err=%b, required 1 0 0 %0d 1",
                  out_valid, out_q, out_r, out_tag, out_err, tag);
      end
`else
      if ({out_valid, out_q, out_r, out_tag, out_err} !== {1'b1, 4'd15, 4'd9, tag, 1'b0}) begin
         failures++;
         $display("FAIL div_zero: got vld=%b q=%0d r=%0d tag=%0d err=%b, required 1 15 9 %0d 0",
                  out_valid, out_q, out_r, out_tag, out_err, tag);
      end
`endif
      next_cycle();
      check_drained("dz");
   endtask

   task automatic test_tag_wrap();
      apply_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 19; i++) begin
         if (i < 17) begin
            in_a = 4'($urandom_range(15, 0));
            in_b = 4'($urandom_range(15, 0));
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         if (i >= 2) begin
            checks++;
            if ({out_valid, out_tag} !== {1'b1, 4'(i - 2)}) begin
               failures++;
               $display("FAIL wrap_tag[%0d]: got vld=%b tag=%0d, required 1 %0d",
                        i - 2, out_valid, out_tag, 4'(i - 2));
            end
         end
         next_cycle();
      end
      check_drained("wrap");
   endtask

   task automatic test_mid_reset();
      apply_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_a = 4'(i + 10); in_b = 4'd3; in_valid = 1'b1;
         next_cycle();
      end
      in_valid = 1'b0;
      checks++;
      if ({out_valid, in_ready} !== 2'b10) begin
         failures++;
         $display("FAIL mrst_pre: got vld=%b rdy=%b, required 1 0", out_valid, in_ready);
      end
      #2;
      rst_n = 1'b0;
      sb.delete();
      exp_tag = '0;
      #1;
      checks++;
      if ({out_valid, in_ready, out_q, out_r, out_tag, out_err} !== {1'b0, 1'b1, 12'h000, 1'b0}) begin
         failures++;
         $display("FAIL mrst_async: got vld=%b rdy=%b q=%0d r=%0d tag=%0d err=%b, required 0 1 0 0 0 0",
                  out_valid, in_ready, out_q, out_r, out_tag, out_err);
      end
      next_cycle();
      rst_n = 1'b1;
      out_ready = 1'b1;
      in_a = 4'd5; in_b = 4'd2; in_valid = 1'b1;
      next_cycle();
      in_valid = 1'b0;
      next_cycle();
      checks++;
      if ({out_valid, out_q, out_r, out_tag} !== {1'b1, 4'd2, 4'd1, 4'd0}) begin
         failures++;
         $display("FAIL mrst_after: got vld=%b q=%0d r=%0d tag=%0d, required 1 2 1 0",
                  out_valid, out_q, out_r, out_tag);
      end
      next_cycle();
      check_drained("mrst");
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_div_zero();
      test_tag_wrap();
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      failures++;
      $display("FAIL watchdog: got simulation still running at %0t, required completion", $time);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

endmodule
